// File: rtl/pio8_edge_irq_pkg.sv
// rtl/pio8_edge_irq_pkg.sv - shared constants for the pio8_edge_irq peripheral
// Purpose: register word addresses, identification constants and the default
//          debounce counter width used by the top level and its sub-module.
package pio8_edge_irq_pkg;

    localparam int DEB_W_DEFAULT = 16;

    localparam logic [2:0] ADDR_TYPE    = 3'd0;
    localparam logic [2:0] ADDR_ID      = 3'd1;
    localparam logic [2:0] ADDR_THRESH  = 3'd2;
    localparam logic [2:0] ADDR_LEVEL   = 3'd3;
    localparam logic [2:0] ADDR_EDGE_EN = 3'd4;
    localparam logic [2:0] ADDR_CAPTURE = 3'd5;
    localparam logic [2:0] ADDR_IRQMASK = 3'd6;

    localparam logic [31:0] TYPE_CODE = 32'h00000108;
    localparam logic [31:0] BLOCK_ID  = 32'hEA690001;

endpackage

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - 2-FF synchroniser plus debounce filter for one pin
// Purpose: brings one asynchronous pin into the clock domain and only lets the
//          filtered level follow it after it has differed for a full threshold.
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_pin       raw asynchronous pin
//   i_thresh_m1 threshold minus one (already clamped so threshold 0 acts as 1)
//   o_filt      debounced level
module pio_debounce_bit #(
    parameter int DEB_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pin,
    input  logic [DEB_W-1:0] i_thresh_m1,
    output logic             o_filt
);

    localparam logic [DEB_W-1:0] ONE = {{(DEB_W-1){1'b0}}, 1'b1};

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [DEB_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt >= i_thresh_m1) begin
                // >= rather than == keeps a lowered threshold from stranding a
                // counter above the new limit, so it can never run away.
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/pio8_edge_irq.sv
// rtl/pio8_edge_irq.sv - eight-input edge-capture interrupt peripheral
// Purpose: debounces the PIO8 pins, latches enabled rising/falling edges into
//          a write-1-to-clear capture register and drives a level interrupt.
// Ports:
//   csi_MCLK_clk         system clock
//   rsi_MRST_reset       asynchronous active-high reset
//   avs_gpio_*           Avalon-MM slave (3-bit word address, registered read)
//   coe_pin_in           PIO8 pin nets P7..P0, asynchronous
//   ins_irq_irq          level interrupt, active-high
module pio8_edge_irq
    import pio8_edge_irq_pkg::*;
#(
    parameter int             DEB_W     = DEB_W_DEFAULT,
    parameter logic [DEB_W-1:0] DEB_RESET = 16'd1000
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [31:0] avs_gpio_writedata,
    output logic [31:0] avs_gpio_readdata,
    input  logic [2:0]  avs_gpio_address,
    input  logic [3:0]  avs_gpio_byteenable,
    input  logic        avs_gpio_write,
    input  logic        avs_gpio_read,
    output logic        avs_gpio_waitrequest,
    input  logic [7:0]  coe_pin_in,
    output logic        ins_irq_irq
);

    logic [DEB_W-1:0] r_thresh;
    logic [7:0]       r_rise_en;
    logic [7:0]       r_fall_en;
    logic [7:0]       r_capture;
    logic [7:0]       r_irq_mask;
    logic [7:0]       r_filt_d;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [7:0]       w_filt;
    logic [DEB_W-1:0] w_thresh_m1;
    logic [31:0]      w_be_mask;
    logic [7:0]       w_set;
    logic [7:0]       w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    // Reads are always registered, so the read strobe itself carries no state.
    assign w_unused = &{1'b0, avs_gpio_read, avs_gpio_writedata[31:16]};

    // Threshold 0 is treated as 1 so filt still lags sync by one cycle.
    assign w_thresh_m1 = (r_thresh == '0) ? '0 : r_thresh - {{(DEB_W-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < 8; i++) begin : g_deb
        pio_debounce_bit #(.DEB_W(DEB_W)) u_deb (
            .i_clk       (csi_MCLK_clk),
            .i_rst       (rsi_MRST_reset),
            .i_pin       (coe_pin_in[i]),
            .i_thresh_m1 (w_thresh_m1),
            .o_filt      (w_filt[i])
        );
    end

    assign w_be_mask = {{8{avs_gpio_byteenable[3]}}, {8{avs_gpio_byteenable[2]}},
                        {8{avs_gpio_byteenable[1]}}, {8{avs_gpio_byteenable[0]}}};

    assign w_set = (w_filt & ~r_filt_d & r_rise_en) | (~w_filt & r_filt_d & r_fall_en);
    assign w_clr = (avs_gpio_write && avs_gpio_address == ADDR_CAPTURE && avs_gpio_byteenable[0])
                   ? avs_gpio_writedata[7:0] : 8'h00;

    always_comb begin
        w_rd_mux = '0;
        case (avs_gpio_address)
            ADDR_TYPE:    w_rd_mux = TYPE_CODE;
            ADDR_ID:      w_rd_mux = BLOCK_ID;
            ADDR_THRESH:  w_rd_mux = 32'(r_thresh);
            ADDR_LEVEL:   w_rd_mux = {24'h0, w_filt};
            ADDR_EDGE_EN: w_rd_mux = {16'h0, r_fall_en, r_rise_en};
            ADDR_CAPTURE: w_rd_mux = {24'h0, r_capture};
            ADDR_IRQMASK: w_rd_mux = {24'h0, r_irq_mask};
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_thresh   <= DEB_RESET;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_capture  <= '0;
            r_irq_mask <= '0;
            r_filt_d   <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_readdata <= w_rd_mux;
            r_filt_d   <= w_filt;
            // Set is OR-ed in after the clear so a coincident edge is never lost.
            r_capture  <= (r_capture & ~w_clr) | w_set;
            r_irq      <= |(r_capture & r_irq_mask);
            if (avs_gpio_write) begin
                case (avs_gpio_address)
                    ADDR_THRESH: r_thresh <= (r_thresh & ~w_be_mask[DEB_W-1:0])
                                           | (avs_gpio_writedata[DEB_W-1:0] & w_be_mask[DEB_W-1:0]);
                    ADDR_EDGE_EN: begin
                        if (avs_gpio_byteenable[0]) r_rise_en <= avs_gpio_writedata[7:0];
                        if (avs_gpio_byteenable[1]) r_fall_en <= avs_gpio_writedata[15:8];
                    end
                    ADDR_IRQMASK: if (avs_gpio_byteenable[0]) r_irq_mask <= avs_gpio_writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign avs_gpio_readdata    = r_readdata;
    assign avs_gpio_waitrequest = 1'b0;
    assign ins_irq_irq          = r_irq;

endmodule

// File: tb/tb_pio8_edge_irq.sv
// tb/tb_pio8_edge_irq.sv - self-checking bench for pio8_edge_irq
module tb_pio8_edge_irq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [2:0]  addr = '0;
    logic [3:0]  be = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        waitreq;
    logic [7:0]  pin = '0;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    pio8_edge_irq dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_gpio_writedata   (wdata),
        .avs_gpio_readdata    (rdata),
        .avs_gpio_address     (addr),
        .avs_gpio_byteenable  (be),
        .avs_gpio_write       (wr),
        .avs_gpio_read        (rd),
        .avs_gpio_waitrequest (waitreq),
        .coe_pin_in           (pin),
        .ins_irq_irq          (irq)
    );

    always #5 clk = ~clk;

    // Reference model: pin history for the synchroniser, a per-bit run length
    // of "synchronised level disagrees with filtered level", and the register
    // state the software sees.
    logic [7:0]  m_hist1, m_hist2;
    logic [7:0]  m_filt, m_filt_prev;
    int          m_run [8];
    logic [15:0] m_thr;
    logic [7:0]  m_rise, m_fall, m_cap, m_mask;
    logic        m_irq;
    logic [31:0] m_rd;

    task automatic model_reset();
        m_hist1 = 0; m_hist2 = 0; m_filt = 0; m_filt_prev = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_thr = 16'd1000; m_rise = 0; m_fall = 0; m_cap = 0; m_mask = 0;
        m_irq = 0; m_rd = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'h00000108;
            3'd1: return 32'hEA690001;
            3'd2: return {16'h0, m_thr};
            3'd3: return {24'h0, m_filt};
            3'd4: return {16'h0, m_fall, m_rise};
            3'd5: return {24'h0, m_cap};
            3'd6: return {24'h0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0]  edges_hit, clr, nf;
        logic [31:0] rd_n;
        logic        irq_n;
        int          need;
        rd_n  = model_read(addr);
        irq_n = (m_cap & m_mask) != 0;
        edges_hit = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_filt[i] && !m_filt_prev[i] && m_rise[i]) edges_hit[i] = 1'b1;
            if (!m_filt[i] && m_filt_prev[i] && m_fall[i]) edges_hit[i] = 1'b1;
        end
        need = (m_thr == 0) ? 1 : int'(m_thr);
        nf = m_filt;
        for (int i = 0; i < 8; i++) begin
            if (m_hist2[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] >= need) begin
                    nf[i] = m_hist2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_filt_prev = m_filt;
        m_filt = nf;
        m_hist2 = m_hist1;
        m_hist1 = pin;
        clr = (wr && addr == 3'd5 && be[0]) ? wdata[7:0] : 8'h00;
        m_cap = (m_cap & ~clr) | edges_hit;
        if (wr) begin
            if (addr == 3'd2 && be[0]) m_thr[7:0] = wdata[7:0];
            if (addr == 3'd2 && be[1]) m_thr[15:8] = wdata[15:8];
            if (addr == 3'd4 && be[0]) m_rise = wdata[7:0];
            if (addr == 3'd4 && be[1]) m_fall = wdata[15:8];
            if (addr == 3'd6 && be[0]) m_mask = wdata[7:0];
        end
        m_irq = irq_n;
        m_rd  = rd_n;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
        chk("readdata_model", rdata, m_rd);
        chk("waitrequest", {31'b0, waitreq}, 32'h0);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; wr = 1'b1;
        tick();
        wr = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd0, 32'h00000108};
        vecs[1] = '{3'd1, 32'hEA690001};
        vecs[2] = '{3'd2, 32'd1000};
        vecs[3] = '{3'd3, 32'h0};
        vecs[4] = '{3'd4, 32'h0};
        vecs[5] = '{3'd5, 32'h0};
        vecs[6] = '{3'd6, 32'h0};
        vecs[7] = '{3'd7, 32'h0};

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_readdata", rdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            bus_read(vecs[v].addr);
            chk($sformatf("reset_read_a%0d", vecs[v].addr), rdata, vecs[v].exp);
        end

        // Rising edge on pin0 with threshold 4: capture at edge 7, irq at edge 8
        bus_write(3'd2, 32'd4, 4'b0011);
        bus_write(3'd4, 32'h0001, 4'b0011);
        bus_write(3'd6, 32'h01, 4'b0001);
        addr = 3'd5;
        pin[0] = 1'b1;
        repeat (7) tick();
        chk("rise_irq_before", {31'b0, irq}, 32'h0);
        chk("rise_cap_before", rdata, 32'h0);
        tick();
        chk("rise_irq_after", {31'b0, irq}, 32'h1);
        chk("rise_cap_after", rdata, 32'h01);
        repeat (2) tick();
        pin[0] = 1'b0;
        repeat (10) tick();

        // Glitch shorter than the threshold never reaches filt
        bus_write(3'd5, 32'hFF, 4'b0001);
        pin[0] = 1'b1;
        repeat (3) tick();
        pin[0] = 1'b0;
        repeat (10) tick();
        bus_read(3'd3);
        chk("glitch_level", rdata, 32'h0);
        bus_read(3'd5);
        chk("glitch_cap", rdata, 32'h0);
        chk("glitch_irq", {31'b0, irq}, 32'h0);

        // Falling-edge capture on pin7
        bus_write(3'd4, 32'h8001, 4'b0011);
        pin[7] = 1'b1;
        repeat (10) tick();
        bus_read(3'd5);
        chk("fall_cap_after_rise", rdata, 32'h0);
        pin[7] = 1'b0;
        repeat (10) tick();
        bus_read(3'd5);
        chk("fall_cap_after_fall", rdata, 32'h80);
        bus_write(3'd5, 32'hFF, 4'b0001);

        // Set wins over a coincident write-1-to-clear
        pin[0] = 1'b1;
        repeat (10) tick();
        pin[0] = 1'b0;
        repeat (10) tick();
        chk("setwin_irq_pre", {31'b0, irq}, 32'h1);
        pin[0] = 1'b1;
        repeat (6) tick();
        bus_write(3'd5, 32'h01, 4'b0001);
        chk("setwin_irq_same", {31'b0, irq}, 32'h1);
        bus_read(3'd5);
        chk("setwin_cap", rdata, 32'h01);
        chk("setwin_irq_held", {31'b0, irq}, 32'h1);
        bus_write(3'd5, 32'h01, 4'b0001);
        chk("clr_irq_same", {31'b0, irq}, 32'h1);
        bus_read(3'd5);
        chk("clr_cap", rdata, 32'h0);
        chk("clr_irq_next", {31'b0, irq}, 32'h0);

        // Reset mid-count with pin3 held high
        pin[3] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_readdata", rdata, 32'h0);
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        bus_write(3'd4, 32'h0008, 4'b0001);
        bus_write(3'd6, 32'h08, 4'b0001);
        addr = 3'd5;
        repeat (1001) tick();
        chk("midrst_irq_before", {31'b0, irq}, 32'h0);
        tick();
        chk("midrst_irq_after", {31'b0, irq}, 32'h1);
        chk("midrst_cap", rdata, 32'h08);

        // Randomised traffic against the model
        bus_write(3'd2, 32'd2, 4'b0011);
        for (int n = 0; n < 2000; n++) begin
            int op;
            op = $urandom_range(0, 9);
            addr = 3'($urandom_range(0, 7));
            wdata = $urandom;
            be = 4'($urandom_range(0, 15));
            if (addr == 3'd2) wdata = $urandom_range(0, 6);
            wr = (op < 3);
            rd = !wr;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) pin[b] = ~pin[b];
            tick();
            wr = 1'b0; rd = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pio8_edge_irq.md
Name: pio8_edge_irq

Overview:
- Avalon-MM slave peripheral that consumes the eight PIO8 pin nets as inputs.
- Synchronises and debounces each input, then detects rising and falling edges.
- Latches enabled edges into a capture register and raises a level interrupt toward the Nios core.
- Gives software event-driven input handling alongside the polled PIO8 data register.

Parameters:
- DEB_W, 16, width of the debounce threshold register and of each per-bit counter.
- DEB_RESET, 16'd1000, reset value of the debounce threshold in clock cycles.

Ports:
- csi_MCLK_clk  in  1  system clock; the only clock.
- rsi_MRST_reset  in  1  asynchronous, active-high reset.
- avs_gpio_writedata  in  32  write data.
- avs_gpio_readdata  out  32  read data, registered.
- avs_gpio_address  in  3  word address.
- avs_gpio_byteenable  in  4  byte lanes for writes.
- avs_gpio_write  in  1  write strobe.
- avs_gpio_read  in  1  read strobe.
- avs_gpio_waitrequest  out  1  tied to 0.
- coe_pin_in  in  8  PIO8 pin nets P7..P0, asynchronous to the clock.
- ins_irq_irq  out  1  level interrupt, active-high.

Behaviour:
- Reset is asynchronous, active-high; one clock domain. All state clears on reset.
  - readdata=0, irq=0, synchroniser and filtered levels=0, counters=0.
  - rise_en=0, fall_en=0, capture=0, irq_mask=0, threshold=DEB_RESET.
- Bus timing:
  - Read data is registered from address every cycle; 1-cycle latency; waitrequest is constantly 0.
  - Writes take effect on the clock edge where write=1.
- Register map (read / write):
  - 0: R 32'h00000108 (type code, 8 inputs); writes ignored.
  - 1: R 32'hEA690001 (block ID); writes ignored.
  - 2: R/W threshold[DEB_W-1:0], zero-extended on read; byteenable[0] writes bits 7:0, byteenable[1] writes bits 15:8.
  - 3: R filtered levels in bits 7:0; writes ignored.
  - 4: R/W rise_en in bits 7:0 (byteenable[0]) and fall_en in bits 15:8 (byteenable[1]).
  - 5: R capture in bits 7:0; write-1-to-clear per bit, gated by byteenable[0].
  - 6: R/W irq_mask in bits 7:0 (byteenable[0]).
  - 7: reads 0; writes ignored.
- Synchroniser: 2-FF per bit, giving sync[7:0].
- Debounce, per bit i:
  - sync==filt: counter cleared.
  - sync!=filt and counter>=threshold-1: filt<=sync, counter<=0.
  - Otherwise counter increments.
  - threshold=0 behaves as threshold=1: filt follows sync one cycle later.
  - A glitch shorter than the threshold never changes filt.
  - Counter saturation cannot occur because the compare is >=.
  - A threshold write mid-count applies from the next cycle; no counter reset.
- Edge detect:
  - filt_d is filt delayed 1 cycle.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - set = (rise & rise_en) | (fall & fall_en).
- Capture update: capture <= (capture & ~clr) | set.
  - When set and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
- irq <= |(capture & irq_mask), registered.
  - Rises 1 cycle after capture updates; falls 1 cycle after the clearing write.
  - A mask change alone also updates irq 1 cycle later.
- Latency from a pin change to the capture bit: 2 (sync) + threshold (filter) + 1 (edge) cycles.
- Reset asserted mid-debounce discards the pending count; filt returns to 0.
  - A pin held at 1 through reset produces a rising edge after release plus the filter delay.

Decomposition:
- Package pio8_edge_irq_pkg holds:
  - Address constants ADDR_TYPE..ADDR_IRQMASK.
  - TYPE_CODE=32'h00000108 and BLOCK_ID=32'hEA690001.
  - Default DEB_W.
- One sub-module, pio_debounce_bit (DEB_W parameter; sync, counter and filt for one bit), instantiated 8 times.
- Top level holds the register file, edge logic and irq.

Test Plan:
- Reset then read addresses 0/1/2/4/5/6 -> readdata 0x108, 0xEA690001, 1000, 0, 0, 0, each 1 cycle after the read.
- threshold=4, rise_en=0x01, irq_mask=0x01; drive pin0 to 1 for 10 cycles -> capture=0x01 at 2+4+1 cycles, irq=1 one cycle later.
- Same setup, 3-cycle pulse on pin0 -> filtered levels stay 0, capture stays 0, irq stays 0.
- fall_en=0x80; pin7 goes 1 then 0 (each held more than threshold cycles) -> capture=0x80 only after the falling transition.
- With capture=0x01, write 0x01 to address 5 in the same cycle as a new rising set on bit0 -> capture stays 0x01 and irq stays 1; a later write 0x01 with no edge -> capture=0, irq=0 next cycle.
- Hold pin3=1, pulse reset mid-count, release -> capture clear in reset; rise_en[3]=1 set before the edge matures gives capture bit3=1 at 2+threshold+1 cycles after release.
